// File: rtl/prio_enc_rr_n_if.sv
// prio_enc_rr_n_if
//   Bundles the request/grant handshake of prio_enc_rr_n.
//   N must match the N of the attached prio_enc_rr_n.
//   mode_rr : 0 = fixed priority (highest index), 1 = round-robin
//   d       : request vector, bit i = source i requesting
//   ready   : consumer accepts q this cycle
//   q       : registered winning index
//   v       : q valid
//   ack     : one-hot, one-cycle acknowledge of the accepted index
//   master  : request sources / consumer side
//   slave   : encoder side
interface prio_enc_rr_n_if #(
   parameter int unsigned N = 8
) ();
   localparam int unsigned W = $clog2(N);

   logic         mode_rr;
   logic [N-1:0] d;
   logic         ready;
   logic [W-1:0] q;
   logic         v;
   logic [N-1:0] ack;

   modport master (output mode_rr, d, ready, input q, v, ack);
   modport slave  (input mode_rr, d, ready, output q, v, ack);
endinterface

// File: rtl/prio_enc_rr_n.sv
// prio_enc_rr_n
//   N-input priority encoder with registered output, valid/ready handshake
//   and selectable fixed-priority or round-robin arbitration. The winning
//   index is held until accepted, then a one-hot ack is returned for one
//   cycle so the granted source can drop its request.
//   clk   : single clock, rising edge
//   rst_n : synchronous, active-low reset
//   bus   : prio_enc_rr_n_if.slave (mode_rr, d, ready in; q, v, ack out)
module prio_enc_rr_n #(
   parameter int unsigned N = 8
) (
   input logic            clk,
   input logic            rst_n,
   prio_enc_rr_n_if.slave bus
);
   localparam int unsigned W = $clog2(N);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t       state_q, state_d;
   logic [W-1:0] q_q,     q_d;
   logic [W-1:0] ptr_q,   ptr_d;
   logic [N-1:0] ack_q,   ack_d;
   logic [N-1:0] grant_oh;
   logic [N-1:0] dm;

   // Highest set index; later iterations overwrite earlier ones.
   function automatic logic [W-1:0] win_fix(input logic [N-1:0] vec);
      logic [W-1:0] res;
      res = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (vec[i]) res = W'(i);
      end
      return res;
   endfunction

   // First set bit scanning start, start-1, ..., wrapping N-1 after 0.
   // The decrementing index with explicit wrap keeps it legal for any N.
   function automatic logic [W-1:0] win_rr(input logic [N-1:0] vec,
                                           input logic [W-1:0] start);
      logic [W-1:0] idx;
      logic [W-1:0] res;
      logic         found;
      idx   = start;
      res   = '0;
      found = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
         if (!found && vec[idx]) begin
            res   = idx;
            found = 1'b1;
         end
         idx = (idx == '0) ? W'(N - 1) : idx - W'(1);
      end
      return res;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         q_q     <= '0;
         ptr_q   <= W'(N - 1);
         ack_q   <= '0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         ptr_q   <= ptr_d;
         ack_q   <= ack_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      q_d      = q_q;
      ptr_d    = ptr_q;
      ack_d    = '0;
      grant_oh = {{(N-1){1'b0}}, 1'b1} << q_q;
      dm       = bus.d & ~grant_oh;
      unique case (state_q)
         IDLE: begin
            if (|bus.d) begin
               q_d     = bus.mode_rr ? win_rr(bus.d, ptr_q) : win_fix(bus.d);
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (bus.ready) begin
               ack_d = grant_oh;
               // The round-robin search after a transfer starts just below
               // the granted index, i.e. from the updated pointer.
               if (bus.mode_rr) ptr_d = (q_q == '0) ? W'(N - 1) : q_q - W'(1);
               if (|dm) q_d = bus.mode_rr ? win_rr(dm, ptr_d) : win_fix(dm);
               else     state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.q   = q_q;
   assign bus.v   = (state_q == HOLD);
   assign bus.ack = ack_q;
endmodule

// File: tb/tb_prio_enc_rr_n.sv
module tb_prio_enc_rr_n;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   prio_enc_rr_n_if #(.N(8)) b8 ();
   prio_enc_rr_n_if #(.N(5)) b5 ();

   prio_enc_rr_n #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
   prio_enc_rr_n #(.N(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(b5.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      b8.d = '0; b8.ready = 1'b0; b8.mode_rr = 1'b0;
      b5.d = '0; b5.ready = 1'b0; b5.mode_rr = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      b8.d = 8'hFF; b8.ready = 1'b1; b8.mode_rr = 1'b0;
      b5.d = '0;    b5.ready = 1'b0; b5.mode_rr = 1'b0;
      step();
      step();
      total++; if (b8.q !== 3'd0)   begin bad++; $display("FAIL reset_q got=%0d exp=0", b8.q); end
      total++; if (b8.v !== 1'b0)   begin bad++; $display("FAIL reset_v got=%0b exp=0", b8.v); end
      total++; if (b8.ack !== 8'h0) begin bad++; $display("FAIL reset_ack got=%h exp=00", b8.ack); end
      b8.d = '0;
      rst_n = 1'b1;
   endtask

   task automatic test_fixed();
      do_reset();
      b8.mode_rr = 1'b0; b8.d = 8'b0010_0101; b8.ready = 1'b0;
      step();
      total++; if (b8.q !== 3'd5 || b8.v !== 1'b1) begin bad++; $display("FAIL fix_load got q=%0d v=%0b exp q=5 v=1", b8.q, b8.v); end
      b8.d = 8'h80;
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if (b8.q !== 3'd5 || b8.v !== 1'b1 || b8.ack !== 8'h0)
            begin bad++; $display("FAIL fix_hold%0d got q=%0d v=%0b ack=%h exp q=5 v=1 ack=00", i, b8.q, b8.v, b8.ack); end
      end
      b8.d = 8'h00; b8.ready = 1'b1;
      step();
      total++; if (b8.ack !== 8'h20 || b8.v !== 1'b0) begin bad++; $display("FAIL fix_ack got ack=%h v=%0b exp ack=20 v=0", b8.ack, b8.v); end
      b8.d = 8'h01; b8.ready = 1'b0;
      step();
      total++; if (b8.q !== 3'd0 || b8.v !== 1'b1 || b8.ack !== 8'h0)
         begin bad++; $display("FAIL fix_d0 got q=%0d v=%0b ack=%h exp q=0 v=1 ack=00", b8.q, b8.v, b8.ack); end
      b8.d = 8'h00; b8.ready = 1'b1;
      step();
      total++; if (b8.ack !== 8'h01 || b8.v !== 1'b0) begin bad++; $display("FAIL fix_ack0 got ack=%h v=%0b exp ack=01 v=0", b8.ack, b8.v); end
      b8.ready = 1'b0;
      step();
      total++; if (b8.ack !== 8'h00) begin bad++; $display("FAIL fix_ack_pulse got ack=%h exp ack=00", b8.ack); end
   endtask

   task automatic test_rr();
      logic [2:0] exp_q [9];
      logic [7:0] exp_ack;
      exp_q = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
      do_reset();
      b8.mode_rr = 1'b1; b8.d = 8'hFF; b8.ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         step();
         exp_ack = (i == 0) ? 8'h00 : (8'h01 << exp_q[i-1]);
         total++; if (b8.q !== exp_q[i] || b8.v !== 1'b1 || b8.ack !== exp_ack)
            begin bad++; $display("FAIL rr_seq%0d got q=%0d v=%0b ack=%h exp q=%0d v=1 ack=%h", i, b8.q, b8.v, b8.ack, exp_q[i], exp_ack); end
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] exp_q [4];
      logic [7:0] exp_ack [4];
      exp_q   = '{3'd7, 3'd6, 3'd7, 3'd6};
      exp_ack = '{8'h00, 8'h80, 8'h40, 8'h80};
      do_reset();
      b8.mode_rr = 1'b0; b8.d = 8'hFF; b8.ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         total++; if (b8.q !== exp_q[i] || b8.v !== 1'b1 || b8.ack !== exp_ack[i])
            begin bad++; $display("FAIL fix_alt%0d got q=%0d v=%0b ack=%h exp q=%0d v=1 ack=%h", i, b8.q, b8.v, b8.ack, exp_q[i], exp_ack[i]); end
      end
   endtask

   task automatic test_reset_mid_hold();
      do_reset();
      b8.mode_rr = 1'b1; b8.d = 8'h08; b8.ready = 1'b0;
      step();
      b8.ready = 1'b1;
      step();
      b8.ready = 1'b0;
      step();
      total++; if (b8.q !== 3'd3 || b8.v !== 1'b1) begin bad++; $display("FAIL mid_setup got q=%0d v=%0b exp q=3 v=1", b8.q, b8.v); end
      rst_n = 1'b0; b8.d = 8'hFF; b8.ready = 1'b1;
      step();
      total++; if (b8.v !== 1'b0 || b8.ack !== 8'h00) begin bad++; $display("FAIL mid_reset got v=%0b ack=%h exp v=0 ack=00", b8.v, b8.ack); end
      rst_n = 1'b1; b8.ready = 1'b0;
      step();
      total++; if (b8.q !== 3'd7 || b8.v !== 1'b1 || b8.ack !== 8'h00)
         begin bad++; $display("FAIL mid_regrant got q=%0d v=%0b ack=%h exp q=7 v=1 ack=00", b8.q, b8.v, b8.ack); end
   endtask

   task automatic test_n5();
      logic [2:0] exp_q [4];
      logic [4:0] exp_ack [4];
      exp_q   = '{3'd4, 3'd0, 3'd4, 3'd0};
      exp_ack = '{5'h00, 5'h10, 5'h01, 5'h10};
      do_reset();
      b5.mode_rr = 1'b1; b5.d = 5'b10001; b5.ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         total++; if (b5.q !== exp_q[i] || b5.v !== 1'b1 || b5.ack !== exp_ack[i])
            begin bad++; $display("FAIL n5_seq%0d got q=%0d v=%0b ack=%h exp q=%0d v=1 ack=%h", i, b5.q, b5.v, b5.ack, exp_q[i], exp_ack[i]); end
      end
      b5.ready = 1'b0; b5.mode_rr = 1'b0;
      step();
      b5.mode_rr = 1'b1;
      step();
      total++; if (b5.q !== 3'd0 || b5.v !== 1'b1 || b5.ack !== 5'h00)
         begin bad++; $display("FAIL n5_toggle got q=%0d v=%0b ack=%h exp q=0 v=1 ack=00", b5.q, b5.v, b5.ack); end
      b5.ready = 1'b1;
      step();
      total++; if (b5.q !== 3'd4 || b5.ack !== 5'h01) begin bad++; $display("FAIL n5_xfer got q=%0d ack=%h exp q=4 ack=01", b5.q, b5.ack); end
      // Held index 2 in fixed mode, transfer sampled in RR mode: {4,1} left,
      // RR from pointer 1 picks 1 where fixed priority would pick 4.
      do_reset();
      b5.mode_rr = 1'b0; b5.d = 5'b00100; b5.ready = 1'b0;
      step();
      b5.d = 5'b10110; b5.ready = 1'b1; b5.mode_rr = 1'b1;
      step();
      total++; if (b5.q !== 3'd1 || b5.ack !== 5'h04) begin bad++; $display("FAIL n5_modesample got q=%0d ack=%h exp q=1 ack=04", b5.q, b5.ack); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      b8.d = '0; b8.ready = 1'b0; b8.mode_rr = 1'b0;
      b5.d = '0; b5.ready = 1'b0; b5.mode_rr = 1'b0;
      test_reset();
      test_fixed();
      test_rr();
      test_back_to_back();
      test_reset_mid_hold();
      test_n5();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
